// File: rtl/bf16_argmax_stream.sv
// Purpose: streaming argmax/argmin over a last-delimited vector of bf16 elements.
// Latency: result valid the cycle after the in_last transfer; one element per cycle with one bubble per vector.
// Backpressure: in_ready drops while a result waits in HOLD; outputs are held until out_ready.
module bf16_argmax_stream #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_val,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_nan_seen,
    output logic             out_all_nan,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_ONE = 1;
    localparam logic [IDX_W:0]   CNT_ONE = 1;
    localparam logic [IDX_W:0]   CNT_MAX = {1'b1, {IDX_W{1'b0}}};
    localparam logic [15:0]      QNAN    = 16'h7FC0;

    // NaN: all-ones exponent with a non-zero mantissa (infinities are ordinary candidates).
    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'd0);
    endfunction

    // Map a non-NaN bf16 onto an unsigned key whose order is the numeric order.
    // -0 is folded onto +0 first so the two compare equal.
    function automatic logic [15:0] order_key(input logic [15:0] x);
        logic [15:0] c;
        c = (x == 16'h8000) ? 16'h0000 : x;
        return c[15] ? ~c : (c | 16'h8000);
    endfunction

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [IDX_W-1:0] idx_cnt_q, idx_cnt_d;
    logic [IDX_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             nan_seen_q, nan_seen_d;
    logic             cand_vld_q, cand_vld_d;
    logic [15:0]      cand_val_q, cand_val_d;
    logic [IDX_W-1:0] cand_idx_q, cand_idx_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [15:0]      out_val_q, out_val_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W:0]   out_count_q, out_count_d;
    logic             out_nan_seen_q, out_nan_seen_d;
    logic             out_all_nan_q, out_all_nan_d;
    logic             out_ovf_q, out_ovf_d;

    logic             in_xfer;
    logic             out_xfer;
    logic             elem_nan;
    logic [15:0]      elem_key;
    logic [15:0]      cand_key;
    logic             better;
    logic [IDX_W-1:0] idx_next;

    // Next-state, running-candidate update and result capture on entry to HOLD.
    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        idx_cnt_d      = idx_cnt_q;
        count_d        = count_q;
        ovf_d          = ovf_q;
        nan_seen_d     = nan_seen_q;
        cand_vld_d     = cand_vld_q;
        cand_val_d     = cand_val_q;
        cand_idx_d     = cand_idx_q;
        out_val_d      = out_val_q;
        out_idx_d      = out_idx_q;
        out_count_d    = out_count_q;
        out_nan_seen_d = out_nan_seen_q;
        out_all_nan_d  = out_all_nan_q;
        out_ovf_d      = out_ovf_q;

        in_xfer  = in_valid && in_ready_q;
        out_xfer = out_valid_q && out_ready;
        elem_nan = is_nan(in_data);
        elem_key = order_key(in_data);
        cand_key = order_key(cand_val_q);
        better   = mode_q ? (elem_key < cand_key) : (elem_key > cand_key);
        idx_next = (idx_cnt_q == IDX_MAX) ? idx_cnt_q : (idx_cnt_q + IDX_ONE);

        case (state_q)
            ST_IDLE: begin
                if (in_xfer) begin
                    mode_d     = in_mode;
                    idx_cnt_d  = '0;
                    count_d    = CNT_ONE;
                    ovf_d      = 1'b0;
                    nan_seen_d = elem_nan;
                    cand_vld_d = !elem_nan;
                    cand_val_d = in_data;
                    cand_idx_d = '0;
                    state_d    = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (in_xfer) begin
                    idx_cnt_d  = idx_next;
                    count_d    = (count_q == CNT_MAX) ? count_q : (count_q + CNT_ONE);
                    ovf_d      = ovf_q || (count_q == CNT_MAX);
                    nan_seen_d = nan_seen_q || elem_nan;
                    // Strict comparison: on equal keys the earlier element wins.
                    if (!elem_nan && (!cand_vld_q || better)) begin
                        cand_vld_d = 1'b1;
                        cand_val_d = in_data;
                        cand_idx_d = idx_next;
                    end
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Snapshot the finished vector into the output registers; they then hold.
        if ((state_q != ST_HOLD) && (state_d == ST_HOLD)) begin
            out_val_d      = cand_vld_d ? cand_val_d : QNAN;
            out_idx_d      = cand_vld_d ? cand_idx_d : '0;
            out_count_d    = count_d;
            out_nan_seen_d = nan_seen_d;
            out_all_nan_d  = !cand_vld_d;
            out_ovf_d      = ovf_d;
        end

        out_valid_d = (state_d == ST_HOLD);
        in_ready_d  = (state_d != ST_HOLD);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mode_q         <= 1'b0;
            idx_cnt_q      <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            nan_seen_q     <= 1'b0;
            cand_vld_q     <= 1'b0;
            cand_val_q     <= '0;
            cand_idx_q     <= '0;
            in_ready_q     <= 1'b1;
            out_valid_q    <= 1'b0;
            out_val_q      <= '0;
            out_idx_q      <= '0;
            out_count_q    <= '0;
            out_nan_seen_q <= 1'b0;
            out_all_nan_q  <= 1'b0;
            out_ovf_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            idx_cnt_q      <= idx_cnt_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            nan_seen_q     <= nan_seen_d;
            cand_vld_q     <= cand_vld_d;
            cand_val_q     <= cand_val_d;
            cand_idx_q     <= cand_idx_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
            out_val_q      <= out_val_d;
            out_idx_q      <= out_idx_d;
            out_count_q    <= out_count_d;
            out_nan_seen_q <= out_nan_seen_d;
            out_all_nan_q  <= out_all_nan_d;
            out_ovf_q      <= out_ovf_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_val      = out_val_q;
    assign out_idx      = out_idx_q;
    assign out_count    = out_count_q;
    assign out_nan_seen = out_nan_seen_q;
    assign out_all_nan  = out_all_nan_q;
    assign out_ovf      = out_ovf_q;

endmodule
